out_packer: RTL and testbench
=============================

OUT_PACKER -- requirements
Module: out_packer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, latches m/n and begins a job.
REQ-004 SHALL have ports: m  in  4  result rows (matrix A rows); n  in  4  result columns (matrix B cols).
REQ-005 SHALL have ports: in_valid  in  1; in_data  in  32  signed accumulator result, row-major order; in_ready  out  1.
REQ-006 SHALL have ports: wr_en  out  1; wr_addr  out  8; wr_data  out  64  output global buffer write port.
REQ-007 SHALL have ports: done  out  1  job complete, level.
REQ-008 Parameter LANES, default 4, meaning 16-bit results packed per 64-bit word.

Function
REQ-009 FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-010 IDLE->RUN on start; m or n equal 0 -> DONE directly, no writes.
REQ-011 RUN: in_ready=1; element accepted when in_valid&&in_ready; column counter col, row counter row.
REQ-012 Words per row WPR=(n+3)>>2 (1..4); element (row,col) goes to address row*WPR+(col>>2), lane col[1:0].
REQ-013 Lane L occupies wr_data[16L+15:16L]; lane 0 = first column of the group in bits [15:0].
REQ-014 Word issued (wr_en=1 for exactly one cycle) the cycle after accepting a lane-3 element or the last column of a row (col==n-1).
REQ-015 Partial word at row end: unused lanes SHALL be 16'h0000; packing register cleared after each issue.
REQ-016 Row end: col wraps to 0, row increments; row-boundary word never merges elements of two rows.
REQ-017 Last element of last row accepted -> FLUSH (issue final word), then DONE next cycle; in_ready=0 in FLUSH/DONE/IDLE.
REQ-018 done=1 in DONE, held until next start; start in DONE clears done and restarts same cycle-following as IDLE.
REQ-019 start while in RUN or FLUSH SHALL be ignored.
REQ-020 Back-to-back in_valid accepted every cycle; throughput one element per cycle, no bubbles at word or row boundaries.
REQ-021 wr_addr/wr_data valid only while wr_en=1; held otherwise.

Reset
REQ-022 rst (sync) SHALL force: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, counters and pack register 0.
REQ-023 rst mid-job SHALL abort: no further writes, partial word discarded, next job starts clean.

Configuration
REQ-024 Macro OUT_SAT_EN defined: in_data clamped to signed 16-bit (>32767 -> 16'h7FFF, <-32768 -> 16'h8000) before packing.
REQ-025 OUT_SAT_EN undefined: in_data[15:0] packed (truncation); no other behaviour differs.

Verification
REQ-026 m=2,n=4, data 1..8 -> two writes: addr0=64'h0004_0003_0002_0001, addr1=64'h0008_0007_0006_0005; done 1 cycle after last write.
REQ-027 m=2,n=6, data 1..12 -> addr0=h0004_0003_0002_0001, addr1=h0000_0000_0006_0005, addr2=h000A_0009_0008_0007, addr3=h0000_0000_000C_000B.
REQ-028 m=1,n=9, in_valid toggling every other cycle -> 3 words at addr 0..2, last = h0000_0000_0000_0009, no write lost.
REQ-029 in_data=32'h0001_2345 and 32'hFFFE_0000 with m=1,n=2 -> word h8000_7FFF with OUT_SAT_EN, h0000_2345 lanes {2345,0000} without.
REQ-030 rst asserted after 3 of 8 elements of m=2,n=4 job -> no write, done=0; then fresh m=1,n=4 job produces only addr0.
REQ-031 start with n=0 -> no wr_en, done=1 within 2 cycles; start during RUN -> ignored, counters unchanged.

Source files
------------

// File: rtl/out_packer_if.sv
// rtl/out_packer_if.sv - element stream in, packed-word write port out
interface out_packer_if #(
    parameter int LANES = 4
) ();
    logic                  in_valid;
    logic [31:0]           in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [7:0]            wr_addr;
    logic [16*LANES-1:0]   wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/out_packer.sv
// rtl/out_packer.sv - packs row-major 16-bit results into wide buffer words; OUT_SAT_EN enables saturation
module out_packer #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   m,
    input  logic [3:0]   n,
    out_packer_if.slave  bus,
    output logic         done
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WW = 16 * LANES;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    m_q, m_d;
    logic [3:0]    n_q, n_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [7:0]    addr_q, addr_d;
    logic [WW-1:0] pack_q, pack_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [WW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;

    logic [15:0]   sample;
    logic [WW-1:0] merged;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          lane_full;

`ifdef OUT_SAT_EN
    always_comb begin
        if ($signed(bus.in_data) > 32'sd32767) begin
            sample = 16'h7FFF;
        end else if ($signed(bus.in_data) < -32'sd32768) begin
            sample = 16'h8000;
        end else begin
            sample = bus.in_data[15:0];
        end
    end
`else
    assign sample = bus.in_data[15:0];
`endif

    // Upper bits only matter when saturation is compiled in.
    logic unused_hi;
    assign unused_hi = ^bus.in_data[31:16];

    assign accept    = (state_q == RUN) && bus.in_valid;
    assign last_col  = (col_q == (n_q - 4'd1));
    assign last_row  = (row_q == (m_q - 4'd1));
    assign lane_full = (lane_q == LW'(LANES - 1));

    always_comb begin
        merged = pack_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                merged[16*i +: 16] = sample;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d    = m;
                    n_d    = n;
                    row_d  = 4'd0;
                    col_d  = 4'd0;
                    lane_d = '0;
                    addr_d = 8'd0;
                    pack_d = '0;
                    state_d = ((m == 4'd0) || (n == 4'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    // Words are issued in address order, so a running counter
                    // yields row*WPR + col/LANES without a multiplier.
                    if (lane_full || last_col) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = merged;
                        pack_d    = '0;
                        addr_d    = addr_q + 8'd1;
                        lane_d    = '0;
                    end else begin
                        pack_d    = merged;
                        lane_d    = lane_q + LW'(1);
                    end
                    if (last_col) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                        if (last_row) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= 4'd0;
            n_q       <= 4'd0;
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            lane_q    <= '0;
            addr_q    <= 8'd0;
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready = (state_q == RUN);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign done         = done_q;
endmodule

// File: tb/tb_out_packer.sv
// tb/tb_out_packer.sv - self-checking bench for out_packer
module tb_out_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] m;
    logic [3:0] n;
    logic       done;

    out_packer_if #(.LANES(4)) bus ();

    out_packer #(.LANES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .n     (n),
        .bus   (bus),
        .done  (done)
    );

    typedef struct {
        int          mm;
        int          nn;
        int          gap;
        int          exp_cnt;
        logic [7:0]  addr;
        logic [63:0] word;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_wr_cyc = 0;
    logic [7:0]  cap_addr[$];
    logic [63:0] cap_data[$];
    logic [31:0] elems[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            cap_addr.push_back(bus.wr_addr);
            cap_data.push_back(bus.wr_data);
            last_wr_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [31:0] x);
`ifdef OUT_SAT_EN
        if ($signed(x) > 32767) return 16'h7FFF;
        if ($signed(x) < -32768) return 16'h8000;
`endif
        return x[15:0];
    endfunction

    task automatic fill_seq(input int cnt, input int base);
        elems.delete();
        for (int i = 0; i < cnt; i++) elems.push_back(32'(base + i));
    endtask

    task automatic run_job(input int mm, input int nn, input int gap, input int start_at,
                           output int stalls, output int done_cyc);
        int w;
        cap_addr.delete();
        cap_data.delete();
        m = 4'(mm);
        n = 4'(nn);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stalls = 0;
        for (int i = 0; i < elems.size(); i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = elems[i];
            if (i == start_at) begin
                start = 1'b1;
                m = 4'd1;
                n = 4'd1;
            end
            w = 0;
            while (!bus.in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
                stalls++;
            end
            if (!bus.in_ready) chk("ready_timeout", 0, 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
    endtask

    // Reference: every row splits into ceil(n/4) words, lanes beyond n are zero.
    task automatic check_model(input string tag, input int mm, input int nn);
        logic [7:0]  ea[$];
        logic [63:0] ed[$];
        int wpr;
        int c;
        logic [63:0] word;
        wpr = (nn + 3) / 4;
        for (int r = 0; r < mm; r++) begin
            for (int wi = 0; wi < wpr; wi++) begin
                word = 64'd0;
                for (int l = 0; l < 4; l++) begin
                    c = wi * 4 + l;
                    if (c < nn) word[16*l +: 16] = conv(elems[r * nn + c]);
                end
                ea.push_back(8'(r * wpr + wi));
                ed.push_back(word);
            end
        end
        chk({tag, "_count"}, 64'(cap_addr.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < cap_addr.size(); i++) begin
            chk({tag, "_addr"}, 64'(cap_addr[i]), 64'(ea[i]));
            chk({tag, "_data"}, cap_data[i], ed[i]);
        end
    endtask

    task automatic find_word(input logic [7:0] a, output logic [63:0] wd, output bit found);
        found = 1'b0;
        wd = '0;
        foreach (cap_addr[i]) begin
            if (cap_addr[i] == a) begin
                wd = cap_data[i];
                found = 1'b1;
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        int stalls;
        int done_cyc;
        logic [63:0] wd;
        bit found;
        int mm;
        int nn;

        vecs.push_back('{2, 4, 0, 2, 8'd0, 64'h0004_0003_0002_0001});
        vecs.push_back('{2, 4, 0, 2, 8'd1, 64'h0008_0007_0006_0005});
        vecs.push_back('{2, 6, 0, 4, 8'd0, 64'h0004_0003_0002_0001});
        vecs.push_back('{2, 6, 0, 4, 8'd1, 64'h0000_0000_0006_0005});
        vecs.push_back('{2, 6, 0, 4, 8'd2, 64'h000A_0009_0008_0007});
        vecs.push_back('{2, 6, 0, 4, 8'd3, 64'h0000_0000_000C_000B});
        vecs.push_back('{1, 9, 1, 3, 8'd2, 64'h0000_0000_0000_0009});
        vecs.push_back('{1, 9, 1, 3, 8'd0, 64'h0004_0003_0002_0001});

        rst = 1'b1;
        start = 1'b0;
        m = 4'd0;
        n = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_wr_en",    64'(bus.wr_en), 0);
        chk("rst_wr_addr",  64'(bus.wr_addr), 0);
        chk("rst_wr_data",  bus.wr_data, 0);
        chk("rst_done",     64'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // n == 0: straight to DONE with no writes
        cap_addr.delete();
        cap_data.delete();
        m = 4'd3;
        n = 4'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk("n0_done", 64'(done), 1);
        chk("n0_in_ready", 64'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("n0_writes", 64'(cap_addr.size()), 0);

        foreach (vecs[v]) begin
            fill_seq(vecs[v].mm * vecs[v].nn, 1);
            run_job(vecs[v].mm, vecs[v].nn, vecs[v].gap, -1, stalls, done_cyc);
            chk("vec_count", 64'(cap_addr.size()), 64'(vecs[v].exp_cnt));
            find_word(vecs[v].addr, wd, found);
            chk("vec_found", 64'(found), 1);
            chk("vec_word", wd, vecs[v].word);
            if (v == 0) begin
                chk("done_latency", 64'(done_cyc - last_wr_cyc), 1);
                chk("no_stall", 64'(stalls), 0);
                chk("done_level", 64'(done), 1);
            end
        end

        // start pulse mid-RUN must be ignored
        fill_seq(8, 1);
        run_job(2, 4, 0, 2, stalls, done_cyc);
        check_model("start_in_run", 2, 4);

        // saturation vs truncation
        elems.delete();
        elems.push_back(32'h0001_2345);
        elems.push_back(32'hFFFE_0000);
        run_job(1, 2, 0, -1, stalls, done_cyc);
        chk("sat_count", 64'(cap_addr.size()), 1);
`ifdef OUT_SAT_EN
        if (cap_data.size() > 0) chk("sat_word", cap_data[0], 64'h0000_0000_8000_7FFF);
`else
        if (cap_data.size() > 0) chk("trunc_word", cap_data[0], 64'h0000_0000_0000_2345);
`endif

        // reset after 3 of 8 elements aborts the job
        cap_addr.delete();
        cap_data.delete();
        m = 4'd2;
        n = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'(i + 1);
            chk("abort_ready", 64'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_writes", 64'(cap_addr.size()), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_in_ready", 64'(bus.in_ready), 0);
        fill_seq(4, 32'h21);
        run_job(1, 4, 0, -1, stalls, done_cyc);
        chk("fresh_count", 64'(cap_addr.size()), 1);
        if (cap_addr.size() > 0) begin
            chk("fresh_addr", 64'(cap_addr[0]), 0);
            chk("fresh_word", cap_data[0], 64'h0024_0023_0022_0021);
        end

        // randomized jobs against the reference model
        for (int j = 0; j < 8; j++) begin
            mm = $urandom_range(1, 5);
            nn = $urandom_range(1, 15);
            elems.delete();
            for (int i = 0; i < mm * nn; i++) begin
                if ($urandom_range(0, 1) == 0)
                    elems.push_back(32'($signed(16'($urandom))));
                else
                    elems.push_back($urandom);
            end
            run_job(mm, nn, (j % 3), -1, stalls, done_cyc);
            check_model("rand", mm, nn);
            if ((j % 3) == 0) chk("rand_no_stall", 64'(stalls), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
